uart_prog_loader: RTL
=====================

// Module: uart_prog_loader
// PURPOSE
//  UART program-download bus master for rooth_soc, driving RIB master port 3 (m3).
//  Receives 8N1 packets on a dedicated pin while debug_en_i=1, checks each one, and issues a
//  single-cycle word write (inst_mem/data_mem/peripherals). Replies with a one-byte ACK on its TX pin.
//  m3 has the highest RIB priority, so a write always completes in the cycle req_o is asserted.
// PARAMETERS
//  CLK_HZ       50_000_000  system clock frequency
//  BAUD         115200      line rate; BIT_CYC = CLK_HZ/BAUD (integer divide)
//  TIMEOUT_CYC  20*BIT_CYC  max idle gap between bytes inside a packet
//  HDR_BYTE     8'hA5       packet start byte
//  ACK_OK       8'h5A       reply: write done
//  ACK_ERR      8'hEE       reply: packet rejected
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  debug_en_i   in   1   loader enable (board pin uart_debug_pin)
//  rx_pin       in   1   UART RX, async, idle high
//  tx_pin       out  1   UART TX, idle high
//  req_o        out  1   RIB m3 request
//  mem_we_o     out  1   RIB m3 write enable
//  mem_addr_o   out  32  RIB m3 address
//  mem_wdata_o  out  32  RIB m3 write data
//  mem_rdata_i  in   32  RIB m3 read data (unused, reserved for readback)
//  halt_o       out  1   =debug_en_i registered; holds core off the bus during download
// BEHAVIOUR
//  - Reset: tx_pin=1; req_o, mem_we_o, halt_o = 0; mem_addr_o, mem_wdata_o = 0; both FSMs idle.
//  - RX front end
//    - rx_pin passes through a 2-FF synchronizer.
//    - A falling edge starts a byte. Start is re-checked at BIT_CYC/2: if high, it is a glitch and is dropped.
//    - Data is sampled LSB-first at the centre of each bit. The stop bit is sampled once.
//    - Stop=0 is a framing error: the byte is discarded and the packet FSM returns to IDLE.
//  - Packet format: HDR, A0..A3, D0..D3 (little-endian), CS.
//    - CS = XOR of A0..D3.
//  - Packet FSM: IDLE -> ADDR(4 bytes) -> DATA(4 bytes) -> CSUM -> WRITE -> ACK -> IDLE.
//    - IDLE ignores every byte other than HDR_BYTE.
//    - CSUM, CS ok and A[1:0]==0 -> WRITE. Any other result -> ACK with ACK_ERR and no bus access.
//    - WRITE lasts exactly 1 cycle: req_o=mem_we_o=1 with addr/wdata valid. The next cycle it enters ACK.
//    - mem_addr_o and mem_wdata_o hold their last values. Strobes are 0 outside WRITE.
//    - ACK loads the TX byte (ACK_OK after a write) and returns to IDLE the same cycle.
//  - Inter-byte gap > TIMEOUT_CYC while in ADDR/DATA/CSUM -> IDLE silently, no ACK.
//  - TX: 8N1 at BIT_CYC per bit, one byte buffer.
//    - If an ACK is requested while TX is busy, it overwrites the pending byte, never the shifting one.
//    - The host is required to wait for each ACK, so no deeper queue exists.
//  - debug_en_i=0 (sampled each cycle)
//    - Packet FSM is forced to IDLE and req_o is 0 next cycle, even mid-packet or mid-WRITE
//      (the abort wins over WRITE).
//    - A TX byte in flight completes.
//    - The RX deserializer keeps running, but its bytes are discarded.
//  - halt_o follows debug_en_i with 1 cycle of latency.
//  - Latency: CS stop-bit sample -> req_o = 2 cycles; req_o -> tx start bit = 2 cycles.
// STRUCTURE
//  - Shared package/defines, added to rooth_defines.v:
//    - `CPU_WIDTH (existing)
//    - LDR_HDR, LDR_ACK_OK, LDR_ACK_ERR
//    - packet state encodings (3-bit): IDLE, ADDR, DATA, CSUM, WRITE, ACK
//  - Sub-module uart_byte_rx: sync + start/bit/stop sampling. Outputs byte_vld (1-cycle pulse), byte, frm_err.
//  - TX shifter and packet FSM stay inline in uart_prog_loader.
// TESTING (CLK_HZ=50M, BAUD=115200; bench BFM drives rx_pin, decodes tx_pin)
//  1. en=1, send A5 00 00 00 00 | 13 00 00 00 | CS=13
//     -> one-cycle req_o=we=1, addr=0x0, wdata=0x00000013; then tx 5A.
//  2. Same packet with CS=14 -> no req_o for whole test; tx EE.
//  3. Addr 0x10000002 (misaligned), correct CS -> no write; tx EE.
//  4. Send A5 + 3 addr bytes, then idle 25*BIT_CYC; then a full valid packet to 0x10000004 = 0xDEADBEEF
//     -> only the second packet writes; exactly one 5A.
//  5. Drop debug_en_i during the D2 byte -> no write, no ACK, halt_o=0 one cycle later;
//     a re-enabled valid packet writes normally.
//  6. rst_n asserted mid-packet (async, off clock edge) -> all outputs at reset values immediately;
//     after release a stray byte 0x13 is ignored; a valid packet writes.

Source files
------------

// File: rtl/uart_prog_loader_pkg.sv
// Constants and state encodings shared by the UART program loader and its RX front end.
package uart_prog_loader_pkg;

  localparam int CPU_WIDTH = 32;

  localparam logic [7:0] LDR_HDR     = 8'hA5;
  localparam logic [7:0] LDR_ACK_OK  = 8'h5A;
  localparam logic [7:0] LDR_ACK_ERR = 8'hEE;

  typedef enum logic [2:0] {
    PK_IDLE  = 3'd0,
    PK_ADDR  = 3'd1,
    PK_DATA  = 3'd2,
    PK_CSUM  = 3'd3,
    PK_WRITE = 3'd4,
    PK_ACK   = 3'd5
  } pkt_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_BUSY
  } tx_state_t;

  function automatic int ldr_bit_cyc(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_prog_loader_byte_rx.sv
// 8N1 byte receiver: 2-FF sync, start re-check at half bit, centre sampling, single stop sample.
module uart_byte_rx
  import uart_prog_loader_pkg::*;
#(
  parameter int BIT_CYC = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic       o_byte_vld,
  output logic [7:0] o_byte,
  output logic       o_frm_err
);

  localparam int CW = $clog2(BIT_CYC + 1);
  localparam logic [CW-1:0] HALF_END = CW'(BIT_CYC / 2 - 1);
  localparam logic [CW-1:0] FULL_END = CW'(BIT_CYC - 1);

  rx_state_t     r_state;
  rx_state_t     w_state_nxt;
  logic [1:0]    r_sync;
  logic          r_rx_d;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_sh;
  logic          r_vld;
  logic [7:0]    r_byte;
  logic          r_err;
  logic          w_rx;
  logic          w_fall;
  logic          w_half;
  logic          w_full;

  assign w_rx   = r_sync[1];
  assign w_fall = r_rx_d & ~w_rx;
  assign w_half = (r_cnt == HALF_END);
  assign w_full = (r_cnt == FULL_END);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RX_IDLE:  if (w_fall) w_state_nxt = RX_START;
      RX_START: if (w_half) w_state_nxt = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_full && r_bit == 3'd7) w_state_nxt = RX_STOP;
      RX_STOP:  if (w_full) w_state_nxt = RX_IDLE;
      default:  w_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RX_IDLE;
      r_sync  <= 2'b11;
      r_rx_d  <= 1'b1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_vld   <= 1'b0;
      r_byte  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_rx};
      r_rx_d  <= w_rx;
      r_state <= w_state_nxt;
      r_vld   <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
        end
        RX_START: r_cnt <= w_half ? '0 : r_cnt + 1'b1;
        RX_DATA: begin
          if (w_full) begin
            r_cnt <= '0;
            r_bit <= r_bit + 1'b1;
            r_sh  <= {w_rx, r_sh[7:1]};
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (w_full) begin
            r_cnt <= '0;
            // A low stop bit drops the byte and flags a framing error instead.
            if (w_rx) begin
              r_vld  <= 1'b1;
              r_byte <= r_sh;
            end else begin
              r_err  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign o_byte_vld = r_vld;
  assign o_byte     = r_byte;
  assign o_frm_err  = r_err;

endmodule

// File: rtl/uart_prog_loader.sv
// UART program-download bus master: receives HDR/ADDR/DATA/CS packets, issues one word write, ACKs on TX.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int         CLK_HZ      = 50_000_000,
  parameter int         BAUD        = 115200,
  parameter int         TIMEOUT_CYC = 20 * (CLK_HZ / BAUD),
  parameter logic [7:0] HDR_BYTE    = LDR_HDR,
  parameter logic [7:0] ACK_OK      = LDR_ACK_OK,
  parameter logic [7:0] ACK_ERR     = LDR_ACK_ERR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 debug_en_i,
  input  logic                 rx_pin,
  output logic                 tx_pin,
  output logic                 req_o,
  output logic                 mem_we_o,
  output logic [CPU_WIDTH-1:0] mem_addr_o,
  output logic [CPU_WIDTH-1:0] mem_wdata_o,
  input  logic [CPU_WIDTH-1:0] mem_rdata_i,
  output logic                 halt_o
);

  localparam int BIT_CYC = ldr_bit_cyc(CLK_HZ, BAUD);
  localparam int TCW     = $clog2(BIT_CYC + 1);
  localparam int GW      = $clog2(TIMEOUT_CYC + 2);
  localparam logic [TCW-1:0] BIT_END = TCW'(BIT_CYC - 1);
  localparam logic [GW-1:0]  GAP_MAX = GW'(TIMEOUT_CYC);

  logic       w_bvld;
  logic [7:0] w_byte;
  logic       w_frm_err;
  logic       w_unused_rdata;

  assign w_unused_rdata = ^mem_rdata_i;

  uart_byte_rx #(.BIT_CYC(BIT_CYC)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rx       (rx_pin),
    .o_byte_vld (w_bvld),
    .o_byte     (w_byte),
    .o_frm_err  (w_frm_err)
  );

  // ---------------- packet FSM ----------------
  pkt_state_t           r_pk;
  pkt_state_t           w_pk_nxt;
  logic [1:0]           r_idx;
  logic [CPU_WIDTH-1:0] r_addr;
  logic [CPU_WIDTH-1:0] r_data;
  logic [7:0]           r_cs;
  logic [GW-1:0]        r_gap;
  logic                 r_ack_ok;
  logic [CPU_WIDTH-1:0] r_mem_addr;
  logic [CPU_WIDTH-1:0] r_mem_wdata;
  logic                 r_halt;
  logic                 w_rx_state;
  logic                 w_tmo;
  logic                 w_go_write;
  logic                 w_ack_req;

  assign w_rx_state = (r_pk == PK_ADDR) || (r_pk == PK_DATA) || (r_pk == PK_CSUM);
  assign w_tmo      = (r_gap > GAP_MAX);

  always_comb begin
    w_pk_nxt = r_pk;
    case (r_pk)
      PK_IDLE: if (w_bvld && w_byte == HDR_BYTE) w_pk_nxt = PK_ADDR;
      PK_ADDR: begin
        if (w_frm_err || w_tmo)          w_pk_nxt = PK_IDLE;
        else if (w_bvld && r_idx == 2'd3) w_pk_nxt = PK_DATA;
      end
      PK_DATA: begin
        if (w_frm_err || w_tmo)          w_pk_nxt = PK_IDLE;
        else if (w_bvld && r_idx == 2'd3) w_pk_nxt = PK_CSUM;
      end
      PK_CSUM: begin
        if (w_frm_err || w_tmo) w_pk_nxt = PK_IDLE;
        else if (w_bvld) begin
          if (w_byte == r_cs && r_addr[1:0] == 2'b00) w_pk_nxt = PK_WRITE;
          else                                          w_pk_nxt = PK_ACK;
        end
      end
      PK_WRITE: w_pk_nxt = PK_ACK;
      PK_ACK:   w_pk_nxt = PK_IDLE;
      default:  w_pk_nxt = PK_IDLE;
    endcase
    // Disabling the loader aborts everything, including a write about to be issued.
    if (!debug_en_i) w_pk_nxt = PK_IDLE;
  end

  assign w_go_write = (r_pk == PK_CSUM) && (w_pk_nxt == PK_WRITE);
  assign w_ack_req  = (r_pk == PK_ACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pk        <= PK_IDLE;
      r_idx       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_cs        <= '0;
      r_gap       <= '0;
      r_ack_ok    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_halt      <= 1'b0;
    end else begin
      r_pk   <= w_pk_nxt;
      r_halt <= debug_en_i;
      if (w_rx_state && !w_bvld) begin
        if (!w_tmo) r_gap <= r_gap + 1'b1;
      end else begin
        r_gap <= '0;
      end
      if (w_bvld) begin
        case (r_pk)
          PK_IDLE: begin
            r_idx <= '0;
            r_cs  <= '0;
          end
          PK_ADDR: begin
            r_addr <= {w_byte, r_addr[CPU_WIDTH-1:8]};
            r_cs   <= r_cs ^ w_byte;
            r_idx  <= r_idx + 1'b1;
          end
          PK_DATA: begin
            r_data <= {w_byte, r_data[CPU_WIDTH-1:8]};
            r_cs   <= r_cs ^ w_byte;
            r_idx  <= r_idx + 1'b1;
          end
          default: ;
        endcase
      end
      if (w_go_write) begin
        r_mem_addr  <= r_addr;
        r_mem_wdata <= r_data;
      end
      if (r_pk == PK_CSUM) r_ack_ok <= w_go_write;
    end
  end

  assign req_o       = (r_pk == PK_WRITE);
  assign mem_we_o    = (r_pk == PK_WRITE);
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign halt_o      = r_halt;

  // ---------------- TX shifter ----------------
  tx_state_t      r_tx_st;
  tx_state_t      w_tx_nxt;
  logic           r_tx_pin;
  logic [8:0]     r_tx_sh;
  logic [TCW-1:0] r_tx_cnt;
  logic [3:0]     r_tx_bits;
  logic [7:0]     r_pend;
  logic           r_pend_vld;
  logic [7:0]     w_ack_byte;
  logic [7:0]     w_tx_byte;
  logic           w_tx_done;
  logic           w_tx_load;

  assign w_ack_byte = r_ack_ok ? ACK_OK : ACK_ERR;
  assign w_tx_done  = (r_tx_st == TX_BUSY) && (r_tx_cnt == BIT_END) && (r_tx_bits == 4'd9);
  // A fresh ACK supersedes any pending byte; the byte on the wire is never disturbed.
  assign w_tx_load  = (w_ack_req && (r_tx_st == TX_IDLE || w_tx_done)) || (w_tx_done && r_pend_vld);
  assign w_tx_byte  = w_ack_req ? w_ack_byte : r_pend;

  always_comb begin
    w_tx_nxt = r_tx_st;
    case (r_tx_st)
      TX_IDLE: if (w_tx_load) w_tx_nxt = TX_BUSY;
      TX_BUSY: if (w_tx_done && !w_tx_load) w_tx_nxt = TX_IDLE;
      default: w_tx_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_st    <= TX_IDLE;
      r_tx_pin   <= 1'b1;
      r_tx_sh    <= '1;
      r_tx_cnt   <= '0;
      r_tx_bits  <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      r_tx_st <= w_tx_nxt;
      if (w_tx_load) begin
        r_tx_sh   <= {1'b1, w_tx_byte};
        r_tx_pin  <= 1'b0;
        r_tx_cnt  <= '0;
        r_tx_bits <= '0;
      end else if (r_tx_st == TX_BUSY) begin
        if (r_tx_cnt == BIT_END) begin
          r_tx_cnt  <= '0;
          r_tx_bits <= r_tx_bits + 1'b1;
          r_tx_pin  <= r_tx_sh[0];
          r_tx_sh   <= {1'b1, r_tx_sh[8:1]};
        end else begin
          r_tx_cnt <= r_tx_cnt + 1'b1;
        end
      end
      if (w_ack_req && r_tx_st == TX_BUSY && !w_tx_done) begin
        r_pend     <= w_ack_byte;
        r_pend_vld <= 1'b1;
      end else if (w_tx_load) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  assign tx_pin = r_tx_pin;

endmodule
